// File: rtl/bist_pattern_signature_pkg.sv
// Shared BIST definitions: default polynomial/seed/golden constants, the
// shift-register next-state function and the controller state encoding.
package bist_pkg;

  localparam logic [7:0] DEF_TAPS   = 8'hB8;
  localparam logic [7:0] DEF_SEED   = 8'h01;
  localparam logic [7:0] DEF_GOLDEN = 8'h00;

  // Controller FSM encoding, exported so benches can correlate traces.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } bist_state_e;

  // Shift left, feeding back the parity of the tapped bits into bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] value,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    fb   = ^(value & taps & mask);
    return ((value << 1) | {31'h0, fb}) & mask;
  endfunction

endpackage

// File: rtl/bist_pattern_signature_shift_reg.sv
// Feedback shift register used both as the pattern LFSR (xor_in = 0) and as
// the response-compacting MISR (xor_in = CUT response).
module bist_shift_reg
  import bist_pkg::*;
#(
  parameter int              W       = 8,
  parameter logic [W-1:0]    TAPS    = W'(DEF_TAPS),
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_xor_in,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;

  assign w_next = W'(lfsr_next(32'(r_q), 32'(TAPS), W));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en) begin
      r_q <= w_next ^ i_xor_in;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bist_pattern_signature.sv
// BIST datapath: LFSR pattern source muxed onto the CUT input, MISR response
// compaction, saturating applied-pattern counter and golden-signature verdict.
module bist_pattern_signature
  import bist_pkg::*;
#(
  parameter int           W      = 8,
  parameter logic [W-1:0] TAPS   = W'(DEF_TAPS),
  parameter logic [W-1:0] SEED   = W'(DEF_SEED),
  parameter logic [W-1:0] GOLDEN = W'(DEF_GOLDEN),
  parameter int           CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             init,
  input  logic             running,
  input  logic             mode,
  input  logic             finish,
  input  logic [W-1:0]     func_data,
  input  logic [W-1:0]     cut_response,
  output logic [W-1:0]     cut_in,
  output logic [W-1:0]     signature,
  output logic [CNT_W-1:0] pattern_count,
  output logic             result_valid,
  output logic             pass,
  output logic             fail
);

  // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             w_step;
  logic [W-1:0]     w_lfsr;
  logic [W-1:0]     w_misr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_pass;
  logic             r_fail;

  assign w_step = running && mode && !init;

  bist_shift_reg #(.W(W), .TAPS(TAPS), .RST_VAL(SEED_EFF)) u_lfsr (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_load     (init),
    .i_load_val (SEED_EFF),
    .i_en       (w_step),
    .i_xor_in   ('0),
    .o_q        (w_lfsr)
  );

  bist_shift_reg #(.W(W), .TAPS(TAPS), .RST_VAL('0)) u_misr (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_load     (init),
    .i_load_val ('0),
    .i_en       (w_step),
    .i_xor_in   (cut_response),
    .o_q        (w_misr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (init) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= sat_inc(r_count);
    end
  end

  // Verdict compares the MISR value present before this edge's update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (init) begin
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (finish) begin
      r_valid <= 1'b1;
      r_pass  <= (w_misr == GOLDEN);
      r_fail  <= (w_misr != GOLDEN);
    end
  end

  assign cut_in        = mode ? w_lfsr : func_data;
  assign signature     = w_misr;
  assign pattern_count = r_count;
  assign result_valid  = r_valid;
  assign pass          = r_pass;
  assign fail          = r_fail;

endmodule

// File: tb/tb_bist_pattern_signature.sv
// Randomized and directed bench for bist_pattern_signature against an
// abstract model of pattern generation, compaction and verdict rules.
module tb_bist_pattern_signature;

  localparam logic [7:0] TAPS   = 8'hB8;
  localparam logic [7:0] SEED   = 8'h01;
  localparam logic [7:0] GOLDEN = 8'h00;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        init = 1'b0, running = 1'b0, mode = 1'b0, finish = 1'b0;
  logic [7:0]  func_data = 8'h00, cut_response = 8'h00;
  logic [7:0]  cut_in, signature, cut_in2, signature2;
  logic [15:0] pattern_count;
  logic [3:0]  pattern_count2;
  logic        result_valid, pass, fail, result_valid2, pass2, fail2;

  int n_tests = 0;
  int n_fail  = 0;

  bist_pattern_signature dut (
    .clock(clock), .reset_n(reset_n), .init(init), .running(running),
    .mode(mode), .finish(finish), .func_data(func_data),
    .cut_response(cut_response), .cut_in(cut_in), .signature(signature),
    .pattern_count(pattern_count), .result_valid(result_valid),
    .pass(pass), .fail(fail)
  );

  // Zero seed must behave like seed 1; narrow counter exposes saturation.
  bist_pattern_signature #(.SEED(8'h00), .CNT_W(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .init(init), .running(running),
    .mode(mode), .finish(finish), .func_data(func_data),
    .cut_response(cut_response), .cut_in(cut_in2), .signature(signature2),
    .pattern_count(pattern_count2), .result_valid(result_valid2),
    .pass(pass2), .fail(fail2)
  );

  always #5 clock = ~clock;

  // Abstract model state
  logic [7:0]  m_lfsr = SEED;
  logic [7:0]  m_misr = 8'h00;
  int          m_cnt  = 0;
  logic        m_rv = 1'b0, m_pass = 1'b0, m_fail = 1'b0;

  function automatic logic [7:0] advance(input logic [7:0] v);
    int ones;
    ones = $countones(v & TAPS);
    return (v << 1) | 8'(ones % 2);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || init) begin
      m_lfsr = SEED; m_misr = 8'h00; m_cnt = 0;
      m_rv = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
    end else begin
      if (finish) begin
        m_rv   = 1'b1;
        m_pass = (m_misr == GOLDEN);
        m_fail = (m_misr != GOLDEN);
      end
      if (running && mode) begin
        m_lfsr = advance(m_lfsr);
        m_misr = advance(m_misr) ^ cut_response;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("cut_in", 32'(cut_in), 32'(mode ? m_lfsr : func_data));
    chk("signature", 32'(signature), 32'(m_misr));
    chk("pattern_count", 32'(pattern_count), 32'(m_cnt));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("fail", 32'(fail), 32'(m_fail));
    chk("cut_in_seed0", 32'(cut_in2), 32'(mode ? m_lfsr : func_data));
    chk("signature_seed0", 32'(signature2), 32'(m_misr));
    chk("count_sat", 32'(pattern_count2), 32'((m_cnt > 15) ? 15 : m_cnt));
    chk("verdict_seed0", 32'({result_valid2, pass2, fail2}), 32'({m_rv, m_pass, m_fail}));
    chk("pass_fail_excl", 32'((pass && fail) || (!result_valid && (pass || fail))), 32'(0));
  end

  task automatic drive(input logic i_init, input logic i_run, input logic i_mode,
                       input logic i_fin, input logic [7:0] i_resp);
    init = i_init; running = i_run; mode = i_mode; finish = i_fin;
    cut_response = i_resp;
    @(posedge clock);
    #1;
  endtask

  initial begin
    func_data = 8'h5A;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cut_in_func", 32'(cut_in), 32'h5A);
    chk("rst_signature", 32'(signature), 32'h00);
    chk("rst_count", 32'(pattern_count), 32'h0);
    chk("rst_flags", 32'({result_valid, pass, fail}), 32'h0);
    #3 reset_n = 1'b1;

    // Init then observe the seed on cut_in
    drive(1, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    chk("init_cut_in", 32'(cut_in), 32'h01);
    chk("init_sig", 32'(signature), 32'h00);
    chk("init_cnt", 32'(pattern_count), 32'h0);
    chk("init_rv", 32'(result_valid), 32'h0);

    drive(0, 1, 1, 0, 8'h00); chk("seq1", 32'(cut_in), 32'h02);
    drive(0, 1, 1, 0, 8'h00); chk("seq2", 32'(cut_in), 32'h04);
    drive(0, 1, 1, 0, 8'h00); chk("seq3", 32'(cut_in), 32'h08);
    drive(0, 1, 1, 0, 8'h00); chk("seq4", 32'(cut_in), 32'h11);
    chk("seq_sig", 32'(signature), 32'h00);
    chk("seq_cnt", 32'(pattern_count), 32'h4);

    // MISR compaction and failing verdict
    drive(1, 0, 1, 0, 8'h00);
    drive(0, 1, 1, 0, 8'hFF); chk("misr_ff", 32'(signature), 32'hFF);
    drive(0, 1, 1, 0, 8'h00); chk("misr_fe", 32'(signature), 32'hFE);
    drive(0, 0, 1, 1, 8'h00);
    chk("fail_verdict", 32'({result_valid, pass, fail}), 32'b101);

    // Full LFSR period with functional gaps interleaved
    drive(1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 255; i++) begin
      func_data = 8'($urandom);
      drive(0, 1, 1, 0, 8'($urandom));
      if (i % 17 == 5) begin
        drive(0, 1, 0, 0, 8'($urandom));
        chk("gap_cut_in_func", 32'(cut_in), 32'(func_data));
      end
    end
    drive(0, 0, 1, 0, 8'h00);
    chk("period_cut_in", 32'(cut_in), 32'h01);
    chk("period_cnt", 32'(pattern_count), 32'd255);
    chk("period_cnt_sat", 32'(pattern_count2), 32'd15);

    // Passing verdict, hold, and clear
    drive(1, 0, 1, 0, 8'h00);
    repeat (6) drive(0, 1, 1, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h00);
    chk("pass_verdict", 32'({result_valid, pass, fail}), 32'b110);
    repeat (10) drive(0, 0, 0, 0, 8'h00);
    chk("pass_hold", 32'({result_valid, pass, fail}), 32'b110);
    drive(1, 0, 0, 0, 8'h00);
    chk("init_clears", 32'({result_valid, pass, fail}), 32'b000);
    drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 0, 1, 8'h00);
    chk("init_over_finish", 32'({result_valid, pass, fail}), 32'b000);

    // Asynchronous abort mid-run
    drive(1, 0, 1, 0, 8'h00);
    repeat (5) drive(0, 1, 1, 0, 8'h3C);
    running = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("abort_cut_in", 32'(cut_in), 32'h01);
    chk("abort_sig", 32'(signature), 32'h00);
    chk("abort_cnt", 32'(pattern_count), 32'h0);
    chk("abort_flags", 32'({result_valid, pass, fail}), 32'h0);
    @(posedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;
    drive(1, 0, 1, 0, 8'h00);
    repeat (4) drive(0, 1, 1, 0, 8'h00);
    chk("rerun_cut_in", 32'(cut_in), 32'h11);
    chk("rerun_cnt", 32'(pattern_count), 32'h4);
    chk("rerun_sig", 32'(signature), 32'h00);

    // Randomized controller activity
    for (int i = 0; i < 3000; i++) begin
      func_data = 8'($urandom);
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_pattern_signature.md
Name: bist_pattern_signature

Overview:
- Datapath stage directly downstream of the BIST controller FSM.
- Consumes the controller outputs init, running, mode and finish.
- Generates pseudo-random test patterns with an LFSR and drives them onto the circuit-under-test (CUT) input, muxed with functional data.
- Compacts CUT responses in a MISR and, on finish, compares the signature against a golden value to produce a pass/fail verdict.

Parameters:
- W, 8: pattern/response/signature width; legal range 2..32.
- TAPS, 8'hB8: feedback mask shared by LFSR and MISR (x^8+x^6+x^5+x^4+1, maximal length).
- SEED, 8'h01: LFSR load value on init. SEED==0 is replaced by 1 internally to avoid lock-up.
- GOLDEN, 8'h00: expected final MISR signature.
- CNT_W, 16: width of the applied-pattern counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init  in  1  from controller: load seed, clear MISR, counter and verdict.
- running  in  1  from controller: test in progress.
- mode  in  1  from controller: 1 = test mode (LFSR drives CUT), 0 = functional.
- finish  in  1  from controller: one-cycle strobe, capture verdict.
- func_data  in  W  functional-path data to the CUT.
- cut_response  in  W  CUT output, combinational response to cut_in in the same cycle.
- cut_in  out  W  CUT input: mode ? lfsr : func_data (combinational mux).
- signature  out  W  current MISR contents.
- pattern_count  out  CNT_W  patterns applied since last init.
- result_valid  out  1  verdict available.
- pass  out  1  signature == GOLDEN at finish.
- fail  out  1  signature != GOLDEN at finish.

Behaviour:
- Reset, asynchronous on reset_n low:
  - lfsr = SEED (nonzero-forced); misr = 0; pattern_count = 0.
  - result_valid = pass = fail = 0.
  - cut_in follows the mux with mode, so it equals func_data while mode = 0.
- Step enable: step = running && mode && !init.
- Priority per rising edge: init > finish > step > hold.
- init = 1:
  - lfsr <= SEED; misr <= 0; pattern_count <= 0.
  - result_valid, pass, fail <= 0.
  - If finish is high in the same cycle, it is ignored.
- step = 1:
  - lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS)}.
  - misr <= {misr[W-2:0], ^(misr & TAPS)} ^ cut_response, where cut_response is the response to the current cut_in.
  - pattern_count <= pattern_count + 1, saturating at all-ones (no wrap).
- running = 1 with mode = 0 (controller gap state): lfsr, misr and counter hold.
- mode = 1 with running = 0: no stepping; cut_in still shows lfsr.
- finish = 1 (and not init), one-cycle latency:
  - result_valid <= 1.
  - pass <= (misr == GOLDEN); fail <= (misr != GOLDEN).
  - The value compared is the misr before any update on that edge. step is never high with finish in the controller sequence; if it is, misr still updates, but the comparison uses the pre-update value.
- Verdict hold: result_valid, pass and fail hold until the next init or reset. A repeated finish re-evaluates against the current misr.
- Invariant: pass and fail are never both 1; both are 0 whenever result_valid = 0.
- LFSR period with default parameters is 255; it wraps to SEED with no special handling.
- Asynchronous reset mid-test aborts immediately to reset values; there is no partial verdict.

Decomposition:
- Shared package bist_pkg holds:
  - the default TAPS/SEED/GOLDEN constants;
  - a function lfsr_next(value, taps, width);
  - the controller state encoding S0..S5, so benches can correlate with the FSM.
- One sub-module, bist_shift_reg (parameterised W/TAPS, inputs load, load_val, en, xor_in), instantiated twice:
  - as the LFSR with xor_in = 0;
  - as the MISR with xor_in = cut_response and load_val = 0.

Test Plan:
- Reset release then init pulse → cut_in with mode = 1 is 0x01; signature 0x00; pattern_count 0; result_valid 0.
- init, then 4 step cycles with cut_response = 0x00 → cut_in sequence 0x01, 0x02, 0x04, 0x08, 0x11; signature stays 0x00; pattern_count 4.
- init, then step with cut_response = 0xFF, then step with 0x00 → signature 0xFF, then 0xFE; finish → result_valid = 1, pass = 0, fail = 1.
- 255 consecutive steps from SEED 0x01 → cut_in returns to 0x01; pattern_count 255. Interleave running = 1 / mode = 0 gaps: the count of applied steps is unchanged and lfsr holds during gaps.
- cut_response held 0x00, finish with GOLDEN = 0x00 → pass = 1, fail = 0. Verdict holds across 10 idle cycles; init clears all three flags next edge. init and finish together → flags 0.
- reset_n asserted mid-run after 5 steps → all outputs return to reset values asynchronously (before the next clock edge). A subsequent init plus step sequence reproduces the scenario-2 values.
